// File: rtl/beta_wb_regfile.sv
// rtl/beta_wb_regfile.sv - beta core write-back stage and integer register file
//
// Commits execute-stage results into x1..x(NumRegs-1), serves two decode operand
// reads with same-cycle bypass of the committing write, tracks per-register
// ownership by in-flight instructions to raise a decode hazard, counts committed
// writes and flags commits that arrive for a register nobody owns.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   wb_issue_i/_wr_i/_rd_i       decode issue of an instruction and its destination
//   wb_reg_wr_en_i/wb_rd_i/
//   wb_result_i                  execute commit strobe, destination and data
//   wb_rsN_addr_i/_used_i        decode read address and operand-needed flag
//   wb_rsN_data_o                operand data (combinational, bypassed)
//   wb_hazard_o                  decode must stall
//   wb_instret_o                 committed-write counter (includes x0 writes)
//   wb_wr_err_o                  sticky: commit to a register with no pending owner

module beta_wb_regfile #(
    parameter int DataWidth = 32,
    parameter int NumRegs   = 32,
    localparam int AddrW    = $clog2(NumRegs)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_issue_i,
    input  logic                 wb_issue_wr_i,
    input  logic [AddrW-1:0]     wb_issue_rd_i,
    input  logic                 wb_reg_wr_en_i,
    input  logic [AddrW-1:0]     wb_rd_i,
    input  logic [DataWidth-1:0] wb_result_i,
    input  logic [AddrW-1:0]     wb_rs1_addr_i,
    input  logic [AddrW-1:0]     wb_rs2_addr_i,
    input  logic                 wb_rs1_used_i,
    input  logic                 wb_rs2_used_i,
    output logic [DataWidth-1:0] wb_rs1_data_o,
    output logic [DataWidth-1:0] wb_rs2_data_o,
    output logic                 wb_hazard_o,
    output logic [31:0]          wb_instret_o,
    output logic                 wb_wr_err_o
);

    // x0 has no storage; it reads as zero and swallows writes.
    logic [DataWidth-1:0] regs_q [1:NumRegs-1];
    logic [DataWidth-1:0] regs_d [1:NumRegs-1];
    logic [NumRegs-1:0]   pending_q;
    logic [NumRegs-1:0]   pending_d;
    logic [31:0]          instret_q;
    logic [31:0]          instret_d;
    logic                 wr_err_q;
    logic                 wr_err_d;

    // Commit and issue are ignored while reset is held, so they are gated here once.
    logic commit_nz;
    logic issue_nz;

    always_comb begin
        commit_nz = !rst_i && wb_reg_wr_en_i && (wb_rd_i != '0);
        issue_nz  = !rst_i && wb_issue_i && wb_issue_wr_i && (wb_issue_rd_i != '0);
    end

    function automatic logic [DataWidth-1:0] read_port(input logic [AddrW-1:0] addr);
        logic [DataWidth-1:0] val;
        val = '0;
        if (rst_i || addr == '0) begin
            val = '0;
        end else if (wb_reg_wr_en_i && wb_rd_i == addr) begin
            val = wb_result_i;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    // A register whose owner commits this cycle is served by the bypass and
    // therefore does not stall.
    function automatic logic pend_eff(input logic [AddrW-1:0] addr);
        return pending_q[addr] && !(wb_reg_wr_en_i && wb_rd_i == addr);
    endfunction

    always_comb begin
        wb_rs1_data_o = read_port(wb_rs1_addr_i);
        wb_rs2_data_o = read_port(wb_rs2_addr_i);
        wb_hazard_o   = 1'b0;
        if (!rst_i) begin
            wb_hazard_o = (wb_rs1_used_i && pend_eff(wb_rs1_addr_i)) ||
                          (wb_rs2_used_i && pend_eff(wb_rs2_addr_i));
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (commit_nz) begin
            regs_d[wb_rd_i] = wb_result_i;
        end

        // Clear before set: when the same register commits and is re-issued in
        // one cycle, the younger issuing instruction keeps ownership.
        pending_d = pending_q;
        if (commit_nz) begin
            pending_d[wb_rd_i] = 1'b0;
        end
        if (issue_nz) begin
            pending_d[wb_issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;

        instret_d = instret_q;
        if (wb_reg_wr_en_i) begin
            instret_d = instret_q + 32'd1;
        end

        wr_err_d = wr_err_q;
        if (commit_nz && !pending_q[wb_rd_i]) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 1; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            instret_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            instret_q <= instret_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_comb begin
        wb_instret_o = instret_q;
        wb_wr_err_o  = wr_err_q;
    end

endmodule

// File: tb/tb_beta_wb_regfile.sv
// tb/tb_beta_wb_regfile.sv - self-checking bench for beta_wb_regfile
module tb_beta_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss, iss_wr, we, u1, u2;
    logic [4:0]  iss_rd, rd, a1, a2;
    logic [31:0] res;
    logic [31:0] d1, d2, instret;
    logic        haz, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    beta_wb_regfile dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wb_issue_i     (iss),
        .wb_issue_wr_i  (iss_wr),
        .wb_issue_rd_i  (iss_rd),
        .wb_reg_wr_en_i (we),
        .wb_rd_i        (rd),
        .wb_result_i    (res),
        .wb_rs1_addr_i  (a1),
        .wb_rs2_addr_i  (a2),
        .wb_rs1_used_i  (u1),
        .wb_rs2_used_i  (u2),
        .wb_rs1_data_o  (d1),
        .wb_rs2_data_o  (d2),
        .wb_hazard_o    (haz),
        .wb_instret_o   (instret),
        .wb_wr_err_o    (err)
    );

    typedef struct {
        logic        rst;
        logic        iss;
        logic [4:0]  iss_rd;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        u1;
        logic        u2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eh;
        logic [31:0] ei;
        logic        ee;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eh;
        logic [31:0] ei;
        logic        ee;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic r, logic is, logic [4:0] ird, logic w, logic [4:0] wrd,
                                logic [31:0] wres, logic [4:0] ra1, logic [4:0] ra2,
                                logic ru1, logic ru2, logic [31:0] x1, logic [31:0] x2,
                                logic xh, logic [31:0] xi, logic xe);
        vec_t v;
        v.rst = r; v.iss = is; v.iss_rd = ird; v.we = w; v.rd = wrd; v.res = wres;
        v.a1 = ra1; v.a2 = ra2; v.u1 = ru1; v.u2 = ru2;
        v.e1 = x1; v.e2 = x2; v.eh = xh; v.ei = xi; v.ee = xe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; iss = 1'b0; iss_wr = 1'b0; iss_rd = '0;
        we = 1'b0; rd = '0; res = '0;
        a1 = '0; a2 = '0; u1 = 1'b0; u2 = 1'b0;
    endtask

    initial begin
        //        rst is ird we rd res           a1 a2 u1 u2 e1            e2            eh ei  ee
        vecs.push_back(mk(1, 0, 0, 1, 5, 32'hDEAD,     5, 0, 0, 0, 32'h0,        32'h0, 0, 0, 0)); // 0 reset, commit ignored
        vecs.push_back(mk(1, 0, 0, 1, 5, 32'hDEAD,     5, 0, 0, 0, 32'h0,        32'h0, 0, 0, 0)); // 1
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        5, 0, 0, 0, 32'h0,        32'h0, 0, 0, 0)); // 2 regs[5] stayed 0
        vecs.push_back(mk(0, 1, 3, 0, 0, 32'h0,        3, 0, 1, 0, 32'h0,        32'h0, 0, 0, 0)); // 3 issue x3
        vecs.push_back(mk(0, 0, 0, 1, 3, 32'h12345678, 3, 0, 1, 0, 32'h12345678, 32'h0, 0, 0, 0)); // 4 commit, bypass
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        3, 0, 1, 0, 32'h12345678, 32'h0, 0, 1, 0)); // 5 stored
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0, 0, 1, 0)); // 6 issue x0
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h0,        32'h0, 0, 1, 0)); // 7 commit x0
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0, 0, 2, 0)); // 8 x0 counted
        vecs.push_back(mk(0, 1, 7, 0, 0, 32'h0,        7, 0, 1, 0, 32'h0,        32'h0, 0, 2, 0)); // 9 same-cycle no stall
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        7, 0, 1, 0, 32'h0,        32'h0, 1, 2, 0)); // 10 hazard
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        7, 0, 0, 0, 32'h0,        32'h0, 0, 2, 0)); // 11 unused operand
        vecs.push_back(mk(0, 0, 0, 1, 7, 32'hA5A5A5A5, 7, 0, 1, 0, 32'hA5A5A5A5, 32'h0, 0, 2, 0)); // 12 commit clears
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        7, 0, 1, 0, 32'hA5A5A5A5, 32'h0, 0, 3, 0)); // 13
        vecs.push_back(mk(0, 1, 9, 0, 0, 32'h0,        0, 9, 0, 1, 32'h0,        32'h0, 0, 3, 0)); // 14 issue x9
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 9, 0, 1, 32'h0,        32'h0, 1, 3, 0)); // 15 rs2 hazard
        vecs.push_back(mk(0, 1, 9, 1, 9, 32'h11,       0, 9, 0, 1, 32'h0,        32'h11, 0, 3, 0)); // 16 set+clear x9
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, 9, 0, 1, 32'h0,        32'h11, 1, 4, 0)); // 17 set won
        vecs.push_back(mk(0, 0, 0, 1, 9, 32'h22,       0, 9, 0, 1, 32'h0,        32'h22, 0, 4, 0)); // 18
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        9, 9, 1, 1, 32'h22,       32'h22, 0, 5, 0)); // 19
        vecs.push_back(mk(0, 0, 0, 1, 4, 32'hCAFEF00D, 4, 0, 1, 0, 32'hCAFEF00D, 32'h0, 0, 5, 0)); // 20 unowned commit
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        4, 3, 1, 1, 32'hCAFEF00D, 32'h12345678, 0, 6, 1)); // 21 err set
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        4, 0, 0, 0, 32'hCAFEF00D, 32'h0, 0, 6, 1)); // 22 sticky
        vecs.push_back(mk(0, 1, 12, 0, 0, 32'h0,       12, 0, 1, 0, 32'h0,       32'h0, 0, 6, 1)); // 23 issue x12
        vecs.push_back(mk(1, 0, 0, 1, 3, 32'h77,       3, 12, 1, 1, 32'h0,       32'h0, 0, 6, 1)); // 24 mid-op reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        12, 3, 1, 1, 32'h0,       32'h0, 0, 0, 0)); // 25 ownership gone
        vecs.push_back(mk(0, 0, 0, 1, 12, 32'h5,       12, 0, 1, 0, 32'h5,       32'h0, 0, 0, 0)); // 26 late commit
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        12, 0, 1, 0, 32'h5,       32'h0, 0, 1, 1)); // 27 err from stale

        idle_inputs();
        rst = 1'b1;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            rst = vecs[i].rst; iss = vecs[i].iss; iss_wr = vecs[i].iss; iss_rd = vecs[i].iss_rd;
            we = vecs[i].we; rd = vecs[i].rd; res = vecs[i].res;
            a1 = vecs[i].a1; a2 = vecs[i].a2; u1 = vecs[i].u1; u2 = vecs[i].u2;
            e.idx = i; e.e1 = vecs[i].e1; e.e2 = vecs[i].e2; e.eh = vecs[i].eh;
            e.ei = vecs[i].ei; e.ee = vecs[i].ee;
            sb.push_back(e);
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d rs1_data", e.idx), d1, e.e1);
            chk($sformatf("v%0d rs2_data", e.idx), d2, e.e2);
            chk($sformatf("v%0d hazard", e.idx), {31'b0, haz}, {31'b0, e.eh});
            chk($sformatf("v%0d instret", e.idx), instret, e.ei);
            chk($sformatf("v%0d wr_err", e.idx), {31'b0, err}, {31'b0, e.ee});
        end

        // Issue without the write qualifier must not create ownership.
        @(negedge clk);
        idle_inputs();
        iss = 1'b1; iss_rd = 5'd15;
        @(negedge clk);
        idle_inputs();
        a1 = 5'd15; u1 = 1'b1;
        #2;
        chk("issue_no_wr hazard", {31'b0, haz}, 32'h0);

        // Counter wrap: preload the counter near its limit, then commit once.
        @(negedge clk);
        idle_inputs();
        force dut.instret_q = 32'hFFFF_FFFF;
        #2;
        chk("wrap preload", instret, 32'hFFFF_FFFF);
        release dut.instret_q;
        @(negedge clk);
        we = 1'b1; rd = 5'd0;
        #2;
        chk("wrap before edge", instret, 32'hFFFF_FFFF);
        @(negedge clk);
        we = 1'b0;
        #2;
        chk("wrap to zero", instret, 32'h0);

        // A strobe held for three cycles is three commits.
        @(negedge clk);
        we = 1'b1; rd = 5'd20; res = 32'h0BAD_F00D;
        repeat (3) @(negedge clk);
        we = 1'b0; rd = '0; res = '0;
        a1 = 5'd20;
        #2;
        chk("held strobe instret", instret, 32'd3);
        chk("held strobe data", d1, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
